// File: rtl/hex_seg_driver.sv
// Two-digit seven-segment output stage for HEX5/HEX4: hex decode or raw segments,
// per-digit blinking and global PWM dimming, two register stages deep.
module hex_seg_driver #(
   parameter int CLK_HZ   = 50000000,
   parameter int BLINK_HZ = 2,
   parameter int PWM_BITS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [15:0]         port_in,
   input  logic                decode,
   input  logic [1:0]          blink_en,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [6:0]          hex5_n,
   output logic [6:0]          hex4_n,
   output logic                blink_phase
);

   localparam int DIV   = CLK_HZ / (2 * BLINK_HZ);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(DIV - 1);
   localparam logic [PWM_BITS-1:0] PWM_FULL = '1;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
         4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
         4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
         4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
      endcase
      return g;
   endfunction

   function automatic logic [6:0] drive_low(input logic lit, input logic [6:0] seg);
      return lit ? ~seg : 7'h7F;
   endfunction

   logic [6:0]          seg5_d, seg4_d;
   logic                blank5_d, blank4_d;
   logic [6:0]          seg5_p1, seg4_p1;
   logic                blank5_p1, blank4_p1;
   logic [1:0]          blink_en_p1;
   logic [PWM_BITS-1:0] brightness_p1;
   logic [CNT_W-1:0]    presc;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_on, lit5, lit4;

   always_comb begin
      seg5_d   = decode ? hex_glyph(port_in[11:8]) : port_in[14:8];
      seg4_d   = decode ? hex_glyph(port_in[3:0])  : port_in[6:0];
      blank5_d = decode & port_in[12];
      blank4_d = decode & port_in[4];
   end

   // stage 1: select glyph or raw segments, sample the controls
   always_ff @(posedge clk) begin
      seg5_p1 <= seg5_d;
      seg4_p1 <= seg4_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blank5_p1     <= 1'b1;
         blank4_p1     <= 1'b1;
         blink_en_p1   <= '0;
         brightness_p1 <= '0;
      end else begin
         blank5_p1     <= blank5_d;
         blank4_p1     <= blank4_d;
         blink_en_p1   <= blink_en;
         brightness_p1 <= brightness;
      end
   end

   // free-running timers; blink never restarts on data or enable changes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc       <= '0;
         blink_phase <= 1'b1;
         pwm_cnt     <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (presc == DIV_LAST) begin
            presc       <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   always_comb begin
      pwm_on = (brightness_p1 == PWM_FULL) || (pwm_cnt < brightness_p1);
      lit5   = !blank5_p1 && (!blink_en_p1[1] || blink_phase) && pwm_on;
      lit4   = !blank4_p1 && (!blink_en_p1[0] || blink_phase) && pwm_on;
   end

   // stage 2: gate and invert to active-low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex5_n <= 7'h7F;
         hex4_n <= 7'h7F;
      end else begin
         hex5_n <= drive_low(lit5, seg5_p1);
         hex4_n <= drive_low(lit4, seg4_p1);
      end
   end

endmodule

// File: tb/tb_hex_seg_driver.sv
// Directed bench for hex_seg_driver with CLK_HZ=20, BLINK_HZ=2 (blink divider 5).
module tb_hex_seg_driver;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] port_in = '0;
   logic        decode = 1'b1;
   logic [1:0]  blink_en = '0;
   logic [3:0]  brightness = 4'hF;
   logic [6:0]  hex5_n, hex4_n;
   logic        blink_phase;

   int n_chk = 0;
   int n_err = 0;

   // inverted (active-low) glyphs for nibbles 0..F
   logic [6:0] inv_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   hex_seg_driver #(.CLK_HZ(20), .BLINK_HZ(2), .PWM_BITS(4)) dut (
      .clk(clk), .reset_n(reset_n), .port_in(port_in), .decode(decode),
      .blink_en(blink_en), .brightness(brightness),
      .hex5_n(hex5_n), .hex4_n(hex4_n), .blink_phase(blink_phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pwm_count(input int cycles, output int lit, output int bad);
      lit = 0;
      bad = 0;
      for (int c = 0; c < cycles; c++) begin
         step(1);
         if (hex4_n == 7'h40) lit++;
         else if (hex4_n != 7'h7F) bad++;
      end
   endtask

   initial begin
      logic [15:0] cur_s, prev_s;
      logic        ph_prev;
      int          lit, bad;

      #1 reset_n = 1'b0;
      #1;
      chk("por_hex5", {9'd0, hex5_n}, 16'h007F);
      chk("por_phase", {15'd0, blink_phase}, 16'h0001);
      step(3);
      port_in = 16'h0000; decode = 1'b1; brightness = 4'hF; blink_en = 2'b00;
      reset_n = 1'b1;
      step(1);
      chk("rel_edge1_hex4", {9'd0, hex4_n}, 16'h007F);
      step(1);
      chk("rel_hex5", {9'd0, hex5_n}, 16'h0040);
      chk("rel_hex4", {9'd0, hex4_n}, 16'h0040);

      for (int i = 0; i < 16; i++) begin
         port_in = 16'(i);
         step(2);
         chk($sformatf("decode_%0h", i), {9'd0, hex4_n}, {9'd0, inv_tab[i]});
      end
      port_in = 16'h1000;
      step(2);
      chk("blank_hex5", {9'd0, hex5_n}, 16'h007F);
      chk("blank_hex4", {9'd0, hex4_n}, 16'h0040);
      port_in = 16'hE0E5;
      step(2);
      chk("ignhi_hex5", {9'd0, hex5_n}, 16'h0040);
      chk("ignhi_hex4", {9'd0, hex4_n}, 16'h0012);

      decode = 1'b0; port_in = 16'h8049;
      step(2);
      chk("raw_hex5", {9'd0, hex5_n}, 16'h007F);
      chk("raw_hex4", {9'd0, hex4_n}, 16'h0036);

      decode = 1'b1; port_in = 16'h0000;
      step(2);
      chk("lat_base", {9'd0, hex4_n}, 16'h0040);
      port_in = 16'h0101;
      step(1);
      chk("lat_n1_hex5", {9'd0, hex5_n}, 16'h0040);
      chk("lat_n1_hex4", {9'd0, hex4_n}, 16'h0040);
      step(1);
      chk("lat_n2_hex5", {9'd0, hex5_n}, 16'h0079);
      chk("lat_n2_hex4", {9'd0, hex4_n}, 16'h0079);

      // asynchronous reset between clock edges
      #3 reset_n = 1'b0;
      #1;
      chk("rst_hex5", {9'd0, hex5_n}, 16'h007F);
      chk("rst_hex4", {9'd0, hex4_n}, 16'h007F);
      chk("rst_phase", {15'd0, blink_phase}, 16'h0001);

      // blink: phase after edge k is 1 for (k/5) even; output uses phase of edge k-1
      blink_en = 2'b01; port_in = 16'h0303;
      step(1);
      reset_n = 1'b1;
      cur_s = 16'h0303;
      for (int i = 1; i <= 30; i++) begin
         if (i == 17) port_in = 16'h0505;
         prev_s = cur_s;
         cur_s = port_in;
         step(1);
         chk($sformatf("phase_%0d", i), {15'd0, blink_phase}, {15'd0, ((i / 5) % 2) == 0});
         if (i >= 2) begin
            ph_prev = (((i - 1) / 5) % 2) == 0;
            chk($sformatf("blk_hex5_%0d", i), {9'd0, hex5_n}, {9'd0, inv_tab[prev_s[11:8]]});
            chk($sformatf("blk_hex4_%0d", i), {9'd0, hex4_n},
                {9'd0, ph_prev ? inv_tab[prev_s[3:0]] : 7'h7F});
         end
      end

      blink_en = 2'b00; port_in = 16'h0000; brightness = 4'h4;
      step(2);
      pwm_count(16, lit, bad);
      chk("pwm4_lit_a", 16'(lit), 16'd4);
      pwm_count(16, lit, bad);
      chk("pwm4_lit_b", 16'(lit), 16'd4);
      chk("pwm4_bad", 16'(bad), 16'd0);
      brightness = 4'h0;
      step(2);
      pwm_count(32, lit, bad);
      chk("pwm0_lit", 16'(lit), 16'd0);
      brightness = 4'hF;
      step(2);
      pwm_count(32, lit, bad);
      chk("pwmF_lit", 16'(lit), 16'd32);
      chk("pwmF_bad", 16'(bad), 16'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hex_seg_driver.md
# hex_seg_driver

Output stage for the HEX5/HEX4 pair of seven-segment displays. It consumes the 16-bit word produced by the upstream Avalon output-port register and drives the two active-low seven-segment digits. It supports hex-glyph decode or raw-segment passthrough, per-digit blinking and global PWM dimming. Pure datapath plus timers; no bus interface.

## Interface
- CLK_HZ, 50000000, clk frequency in Hz
- BLINK_HZ, 2, blink rate in Hz (one full on+off period)
- PWM_BITS, 4, width of brightness control and PWM counter
- clk  in  1  system clock
- reset_n  in  1  reset_n, asynchronous, active-low
- port_in  in  16  word from upstream output port; [15:8] = HEX5 byte, [7:0] = HEX4 byte
- decode  in  1  1 = hex-decode mode, 0 = raw-segment mode
- blink_en  in  2  [1] blinks HEX5, [0] blinks HEX4
- brightness  in  PWM_BITS  duty control; 0 = dark, all-ones = full on
- hex5_n  out  7  HEX5 segments {g,f,e,d,c,b,a}, active-low
- hex4_n  out  7  HEX4 segments {g,f,e,d,c,b,a}, active-low
- blink_phase  out  1  current blink phase, 1 = visible

## Operation
- **Per-byte interpretation, decode=1:**
  - byte[4] = 1 blanks the digit.
  - Otherwise byte[3:0] maps to an active-high glyph: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
  - byte[7:5] are ignored.
- **Per-byte interpretation, decode=0:** byte[6:0] are active-high segments and are passed through. byte[7] is ignored.
- **Stage 1 (registered):** glyph/raw select for both digits. Inputs port_in, decode, blink_en and brightness are sampled here.
- **Stage 2 (registered):** gating, then inversion to active-low outputs. A digit is lit when all of the following hold:
  - not blanked by byte[4];
  - blink_en bit = 0 or blink_phase = 1;
  - pwm_on = 1.
  - An unlit digit drives 7'h7F.
- **Blink prescaler:**
  - DIV = CLK_HZ/(2*BLINK_HZ), integer truncation; DIV must be ≥ 1.
  - Counter runs 0..DIV-1. When it reaches DIV-1 it wraps to 0 and blink_phase toggles.
  - The prescaler runs continuously, independent of blink_en.
- **PWM:**
  - pwm_cnt is PWM_BITS wide, free-running and wraps.
  - pwm_on = (brightness == all-ones) OR (pwm_cnt < brightness).
  - Result: brightness 0 is never lit, and all-ones is always lit with no flicker.
- **Reset (async assert, sync release):**
  - hex5_n = hex4_n = 7'h7F.
  - blink_phase = 1.
  - Prescaler = 0, pwm_cnt = 0, stage 1 regs = blank.
- Reset mid-operation: outputs return to 7'h7F immediately, with no wait for a clock edge.
- Changes to port_in during the invisible blink phase are tracked internally and appear when the phase returns to 1. The blink timer is not restarted.
- Change to blink_en mid-phase takes effect on the current phase value (2-cycle latency). The prescaler is not reset.
- **Simultaneous events:** a port_in change and a blink_phase toggle in the same cycle both take effect. The output reflects the new data gated by the new phase after normal latency.

## Timing
- Data latency port_in/decode/brightness → hex*_n: 2 clk cycles. A change sampled at edge N is visible after edge N+1.
- blink_phase toggles on the edge where the prescaler wraps. The gating effect appears on hex*_n one cycle later.
- Blink period = 2*DIV cycles. PWM period = 2^PWM_BITS cycles.
- No handshakes. The upstream port holds its value until rewritten, and no glitch filtering is required.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Test plan
Parameters for sim: CLK_HZ=20, BLINK_HZ=2, so DIV=5.
- **Reset values:** assert reset_n=0 mid-run → hex5_n = hex4_n = 7'h7F and blink_phase = 1 asynchronously. After release with port_in=16'h0000, decode=1, brightness=F, blink_en=0 → both digits read 7'h40 ('0') two edges later.
- **Decode sweep:** decode=1, brightness=F. Sweep port_in[3:0] over 0..F → hex4_n equals the inverted glyph table (e.g. A → 7'h08, F → 7'h0E). Then set port_in=16'h1000 → hex5_n = 7'h7F (blank bit).
- **Raw mode:** decode=0, port_in=16'h8049 → hex5_n = 7'h7F and hex4_n = 7'h36; bit7 is ignored.
- **Blink:** blink_en=2'b01, port_in=16'h0303 → blink_phase toggles every 5 cycles. hex4_n alternates 7'h30 / 7'h7F with a 10-cycle period; hex5_n stays 7'h30. Change port_in during the dark phase → the new value appears at the next visible phase with no timer restart.
- **PWM:** brightness=4 → hex*_n lit for exactly 4 of every 16 cycles. brightness=0 → never lit. brightness=F → lit continuously over ≥ 32 cycles.
- **Latency:** step port_in from 16'h0000 to 16'h0101 at edge N → hex*_n change to 7'h79 on edge N+2, not earlier.
